// File: rtl/cache_tile_collect_if.sv
// Request, tile-beat and output handshakes between the fetch pipe (master)
// and the tile collector (slave).
interface cache_tile_collect_if #(
   parameter int DATA_WDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_delta_x;
   logic [1:0]           req_delta_y;

   logic                 tile_valid;
   logic                 tile_ready;
   logic [1:0]           tile_x;
   logic [1:0]           tile_y;
   logic                 tile_chg_luma;
   logic                 tile_chg_chma;
   logic [DATA_WDTH-1:0] tile_data;

   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           out_x;
   logic [1:0]           out_y;
   logic [DATA_WDTH-1:0] out_data;
   logic                 out_last;

   modport master (
      output req_valid, req_delta_x, req_delta_y,
      output tile_valid, tile_x, tile_y, tile_chg_luma, tile_chg_chma, tile_data,
      output out_ready,
      input  req_ready, tile_ready,
      input  out_valid, out_x, out_y, out_data, out_last
   );

   modport slave (
      input  req_valid, req_delta_x, req_delta_y,
      input  tile_valid, tile_x, tile_y, tile_chg_luma, tile_chg_chma, tile_data,
      input  out_ready,
      output req_ready, tile_ready,
      output out_valid, out_x, out_y, out_data, out_last
   );
endinterface

// File: rtl/cache_tile_collect.sv
// Collects (dx+1)*(dy+1) raster tile beats per request through a 2-entry FIFO; head is
// registered (1-cycle push-to-out); tile_ready drops when full or all beats taken, ignoring out_ready.
module cache_tile_collect #(
   parameter int DATA_WDTH  = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   cache_tile_collect_if.slave  bus,
   output logic                 o_done,
   output logic                 o_order_err,
   output logic [4:0]           o_luma_cnt,
   output logic [4:0]           o_chma_cnt
);
   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   typedef struct packed {
      logic [1:0]           x;
      logic [1:0]           y;
      logic [DATA_WDTH-1:0] data;
      logic                 last;
   } ent_t;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_dx, r_dy, r_exp_x, r_exp_y;
   logic [4:0] r_total, r_acc;
   logic [4:0] r_luma, r_chma;
   logic       r_err, r_done;
   ent_t       r_mem [2];
   logic       r_wr_ptr, r_rd_ptr;
   logic [1:0] r_cnt;

   logic       w_req_acc, w_push, w_pop, w_last_pop, w_full;
   logic       w_req_ready, w_tile_ready;
   logic [4:0] w_tx, w_ty, w_total;
   ent_t       w_head, w_push_ent;

   assign w_tx    = {3'b000, bus.req_delta_x} + 5'd1;
   assign w_ty    = {3'b000, bus.req_delta_y} + 5'd1;
   assign w_total = w_tx * w_ty;

   assign w_full     = (r_cnt == 2'(FIFO_DEPTH));
   assign w_head     = r_mem[r_rd_ptr];
   assign w_req_acc  = bus.req_valid & w_req_ready;
   assign w_push     = bus.tile_valid & w_tile_ready;
   assign w_pop      = (r_cnt != 2'd0) & bus.out_ready;
   assign w_last_pop = w_pop & w_head.last;

   assign w_push_ent.x    = bus.tile_x;
   assign w_push_ent.y    = bus.tile_y;
   assign w_push_ent.data = bus.tile_data;
   assign w_push_ent.last = ((r_acc + 5'd1) == r_total);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_req_ready  = 1'b0;
      w_tile_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) w_state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            w_tile_ready = !w_full && (r_acc < r_total);
            if (w_last_pop) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_dx     <= '0;
         r_dy     <= '0;
         r_total  <= '0;
         r_acc    <= '0;
         r_exp_x  <= '0;
         r_exp_y  <= '0;
         r_luma   <= '0;
         r_chma   <= '0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= '0;
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      end else begin
         r_done <= w_last_pop;
         if (w_req_acc) begin
            r_dx    <= bus.req_delta_x;
            r_dy    <= bus.req_delta_y;
            r_total <= w_total;
            r_acc   <= '0;
            r_exp_x <= '0;
            r_exp_y <= '0;
            r_luma  <= '0;
            r_chma  <= '0;
            r_err   <= 1'b0;
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_ent;
            r_wr_ptr        <= ~r_wr_ptr;
            r_acc           <= r_acc + 5'd1;
            r_luma          <= r_luma + {4'b0000, bus.tile_chg_luma};
            r_chma          <= r_chma + {4'b0000, bus.tile_chg_chma};
            // Out-of-order beats are flagged but still forwarded downstream.
            if ((bus.tile_x != r_exp_x) || (bus.tile_y != r_exp_y)) r_err <= 1'b1;
            if (r_exp_x == r_dx) begin
               r_exp_x <= '0;
               r_exp_y <= r_exp_y + 2'd1;
            end else begin
               r_exp_x <= r_exp_x + 2'd1;
            end
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.tile_ready = w_tile_ready;
   assign bus.out_valid  = (r_cnt != 2'd0);
   assign bus.out_x      = w_head.x;
   assign bus.out_y      = w_head.y;
   assign bus.out_data   = w_head.data;
   assign bus.out_last   = w_head.last;

   assign o_done      = r_done;
   assign o_order_err = r_err;
   assign o_luma_cnt  = r_luma;
   assign o_chma_cnt  = r_chma;
endmodule

// File: tb/tb_cache_tile_collect.sv
// Directed bench for cache_tile_collect with a queue scoreboard on the output stream.
module tb_cache_tile_collect;
   localparam int DW = 32;

   typedef struct packed {
      logic [1:0]    x;
      logic [1:0]    y;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       done, order_err;
   logic [4:0] luma_cnt, chma_cnt;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_pops = 0;
   int   n_done = 0;
   int   tb_total = 0;
   int   tb_acc = 0;
   exp_t sb[$];
   exp_t e;

   cache_tile_collect_if #(.DATA_WDTH(DW)) bus ();

   cache_tile_collect #(.DATA_WDTH(DW), .FIFO_DEPTH(2)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .bus         (bus),
      .o_done      (done),
      .o_order_err (order_err),
      .o_luma_cnt  (luma_cnt),
      .o_chma_cnt  (chma_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [1:0] dx, input logic [1:0] dy);
      bus.req_valid   = 1'b1;
      bus.req_delta_x = dx;
      bus.req_delta_y = dy;
      for (int i = 0; i < 100 && !bus.req_ready; i++) tick();
      chk("req_ready_wait", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      tb_total = (int'(dx) + 1) * (int'(dy) + 1);
      tb_acc   = 0;
   endtask

   task automatic send_tile(input logic [1:0] x, input logic [1:0] y,
                            input logic lu, input logic ch, input logic [DW-1:0] d);
      exp_t t;
      bus.tile_valid    = 1'b1;
      bus.tile_x        = x;
      bus.tile_y        = y;
      bus.tile_chg_luma = lu;
      bus.tile_chg_chma = ch;
      bus.tile_data     = d;
      for (int i = 0; i < 100 && !bus.tile_ready; i++) tick();
      chk("tile_ready_wait", bus.tile_ready, 1);
      t.x = x; t.y = y; t.data = d; t.last = ((tb_acc + 1) == tb_total);
      sb.push_back(t);
      tb_acc++;
      tick();
      bus.tile_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && !done; i++) tick();
      chk("done_wait", done, 1);
   endtask

   // Output-side scoreboard and done-pulse counter.
   always @(negedge clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         n_pops++;
         n_vec++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL pop_unexpected: observed x=%0d y=%0d, expected no output", bus.out_x, bus.out_y);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_x", bus.out_x, e.x);
            chk("out_y", bus.out_y, e.y);
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
         end
      end
      if (reset && done) n_done++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, d0;
      reset = 1'b0;
      bus.req_valid = 0; bus.req_delta_x = 0; bus.req_delta_y = 0;
      bus.tile_valid = 0; bus.tile_x = 0; bus.tile_y = 0;
      bus.tile_chg_luma = 0; bus.tile_chg_chma = 0; bus.tile_data = 0;
      bus.out_ready = 0;
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_order_err", order_err, 0);
      chk("rst_luma", luma_cnt, 0);
      chk("rst_chma", chma_cnt, 0);
      chk("rst_out_x", bus.out_x, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_tile_ready", bus.tile_ready, 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // Single tile: head visible the cycle after accept, done one cycle after pop.
      bus.out_ready = 1;
      d0 = n_done;
      send_req(0, 0);
      send_tile(0, 0, 1, 0, 32'hA5A5_0001);
      chk("t1_out_valid", bus.out_valid, 1);
      chk("t1_out_last", bus.out_last, 1);
      tick();
      chk("t1_done", done, 1);
      chk("t1_req_ready", bus.req_ready, 1);
      chk("t1_luma", luma_cnt, 1);
      chk("t1_order_err", order_err, 0);
      tick();
      chk("t1_done_low", done, 0);
      chk("t1_done_count", n_done - d0, 1);

      // 3x2 back-to-back.
      p0 = n_pops; d0 = n_done;
      send_req(2, 1);
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 3; x++)
            send_tile(2'(x), 2'(y), 0, 0, $urandom);
      wait_done();
      tick();
      chk("t2_pops", n_pops - p0, 6);
      chk("t2_done_count", n_done - d0, 1);
      chk("t2_order_err", order_err, 0);
      chk("t2_sb_empty", sb.size(), 0);

      // Backpressure on a 4x4 request.
      bus.out_ready = 0;
      p0 = n_pops; d0 = n_done;
      send_req(3, 3);
      send_tile(0, 0, 0, 0, $urandom);
      send_tile(1, 0, 0, 0, $urandom);
      bus.tile_valid = 1; bus.tile_x = 2; bus.tile_y = 0;
      chk("t3_full_tile_ready", bus.tile_ready, 0);
      chk("t3_full_out_valid", bus.out_valid, 1);
      tick(); tick();
      chk("t3_full_tile_ready2", bus.tile_ready, 0);
      chk("t3_no_pops", n_pops - p0, 0);
      bus.out_ready = 1;
      for (int k = 2; k < 16; k++)
         send_tile(2'(k % 4), 2'(k / 4), 0, 0, $urandom);
      bus.tile_valid = 1; bus.tile_x = 0; bus.tile_y = 0;
      chk("t3_17th_tile_ready", bus.tile_ready, 0);
      wait_done();
      tick();
      bus.tile_valid = 0;
      chk("t3_pops", n_pops - p0, 16);
      chk("t3_done_count", n_done - d0, 1);
      chk("t3_sb_empty", sb.size(), 0);

      // Raster-order violation still forwards both beats.
      d0 = n_done;
      send_req(1, 0);
      send_tile(1, 0, 0, 0, $urandom);
      chk("t4_order_err_set", order_err, 1);
      send_tile(0, 0, 0, 0, $urandom);
      wait_done();
      tick();
      chk("t4_done_count", n_done - d0, 1);
      chk("t4_order_err_hold", order_err, 1);

      // Counters; the request accept also clears the sticky error.
      send_req(1, 1);
      chk("t5_order_err_clr", order_err, 0);
      send_tile(0, 0, 1, 1, $urandom);
      send_tile(1, 0, 0, 0, $urandom);
      send_tile(0, 1, 1, 0, $urandom);
      send_tile(1, 1, 1, 0, $urandom);
      wait_done();
      chk("t5_luma", luma_cnt, 3);
      chk("t5_chma", chma_cnt, 1);
      tick();

      // Reset in the middle of a request.
      bus.out_ready = 0;
      send_req(1, 1);
      send_tile(0, 0, 1, 0, 32'h1234_5679);
      send_tile(1, 0, 1, 0, 32'h0BAD_F00D);
      chk("t6_pre_luma", luma_cnt, 2);
      chk("t6_pre_out_valid", bus.out_valid, 1);
      d0 = n_done;
      reset = 1'b0;
      #1;
      chk("t6_out_valid", bus.out_valid, 0);
      chk("t6_out_x", bus.out_x, 0);
      chk("t6_out_data", bus.out_data, 0);
      chk("t6_out_last", bus.out_last, 0);
      chk("t6_luma", luma_cnt, 0);
      chk("t6_done", done, 0);
      chk("t6_tile_ready", bus.tile_ready, 0);
      sb.delete();
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      chk("t6_req_ready", bus.req_ready, 1);
      chk("t6_no_done", n_done - d0, 0);
      chk("t6_done_low", done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cache_tile_collect.md
Name: cache_tile_collect

Overview:
- Receive-side endpoint of the per-tile stream produced by the cache set-input stage.
- A reference block request is expanded into (delta_x+1)*(delta_y+1) raster-ordered tile beats; this block accepts one request descriptor, then collects exactly that many beats through a 2-entry FIFO.
- It checks raster order, counts luma/chroma tile changes, tags the final beat as last, and pulses done when the last beat leaves.
- It sits between the tag-compare/fetch pipe and the block-assembly logic.

Parameters:
- DATA_WDTH, 32, width of per-tile payload carried alongside coordinates.
- FIFO_DEPTH, 2, tile FIFO entries; fixed at 2. Only 2 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request descriptor valid
- req_ready  out  1  collector can take a descriptor
- req_delta_x  in  2  last tile x index in the request (0..3)
- req_delta_y  in  2  last tile y index in the request (0..3)
- tile_valid  in  1  tile beat valid
- tile_ready  out  1  tile beat accepted when high with tile_valid
- tile_x  in  2  tile x index (curr_x)
- tile_y  in  2  tile y index (curr_y)
- tile_chg_luma  in  1  luma position advanced on this tile
- tile_chg_chma  in  1  chroma position advanced on this tile
- tile_data  in  DATA_WDTH  payload
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_x  out  2  head tile x
- out_y  out  2  head tile y
- out_data  out  DATA_WDTH  head payload
- out_last  out  1  head is final tile of the request
- done  out  1  one-cycle pulse when the last tile is popped
- order_err  out  1  sticky raster-order violation flag
- luma_cnt  out  5  accepted tiles with tile_chg_luma=1
- chma_cnt  out  5  accepted tiles with tile_chg_chma=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - FIFO empty; out_valid=0; done=0; order_err=0; luma_cnt=0; chma_cnt=0.
  - Expected x/y=0; accepted count=0; popped count=0.
  - out_x, out_y, out_data and out_last read 0.
- Reset asserted mid-request abandons the request. No done pulse is produced.
- States:
  - IDLE: req_ready=1, tile_ready=0. On req_valid, latch dx/dy and set total=(dx+1)*(dy+1) (5-bit, 1..16). Clear counts, order_err and expected x/y. Go to COLLECT.
  - COLLECT: req_ready=0. tile_ready=1 iff FIFO occupancy<2 and accepted<total.
  - tile_ready does not depend on out_ready; a pop does not free a slot in the same cycle.
- Accept (tile_valid&tile_ready):
  - Push {x,y,data,last}, where last=1 iff this is accepted beat number total.
  - accepted+1; luma_cnt+=tile_chg_luma; chma_cnt+=tile_chg_chma.
  - If (tile_x,tile_y) differs from the expected pair, set order_err=1. The beat is still forwarded.
  - Expected pair advances raster-style: x==dx wraps to 0 and y increments; otherwise x increments.
- Latency: a beat accepted at edge N is visible on out_* after edge N (out_valid high in cycle N+1) if the FIFO was empty. out_* comes from a registered FIFO head.
- Pop (out_valid&out_ready): advance the head. Simultaneous push and pop is legal at occupancy 1 and leaves occupancy at 1.
- Completion: popping a head with out_last=1 registers done=1 for exactly one cycle and returns to IDLE.
  - A new request may be accepted in the first IDLE cycle (the cycle done is high).
- order_err and the counters hold their values in IDLE until the next request is accepted.
- Beats presented while tile_ready=0 (IDLE, FIFO full, or all beats accepted) are not consumed.
- req_delta_x/req_delta_y are sampled only on request acceptance.

Test Plan:
- Single tile: req dx=0,dy=0, then one beat (0,0) with chg_luma=1, out_ready=1 → out_valid in the next cycle with out_last=1. done pulses one cycle after the pop; luma_cnt=1, order_err=0.
- 3x2 request: dx=2,dy=1, beats (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) back-to-back, out_ready=1 → 6 outputs in order, out_last only on (2,1), done once, order_err=0.
- Backpressure: dx=3,dy=3, out_ready=0 → tile_ready drops after 2 accepts. Release out_ready → all 16 tiles emerge in order with no loss or duplication; the 17th presented beat is not accepted.
- Order error: dx=1,dy=0, beats (1,0) then (0,0) → order_err=1 after the first accept. Both beats are forwarded and done still pulses. order_err clears on the next req accept.
- Counters: dx=1,dy=1 with chg_luma pattern 1,0,1,1 and chg_chma pattern 1,0,0,0 → luma_cnt=3, chma_cnt=1.
- Reset mid-op: assert reset after 2 of 4 beats → all outputs return to 0 immediately. No done pulse; req_ready=1 after release.
